// File: rtl/ibex_rf_wb_arbiter.sv
// Write-port arbiter for the integer and FP register files. Writeback-stage writes pass
// straight through; FPU results queue up and drain into the FP port when it is idle.
module ibex_rf_wb_arbiter #(
  parameter bit          ResetAll = 1'b0,
  parameter int unsigned FpQDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        wb_we_int_i,
  input  logic        wb_we_fp_i,
  input  logic        wb_lsu_to_fp_i,

  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_waddr_i,
  input  logic [31:0] fpu_wdata_i,

  input  logic [4:0]  hazard_raddr_i,
  output logic        hazard_o,
  output logic        fp_pending_o,

  output logic        rf_int_we_o,
  output logic [4:0]  rf_int_waddr_o,
  output logic [31:0] rf_int_wdata_o,
  output logic        rf_fp_we_o,
  output logic [4:0]  rf_fp_waddr_o,
  output logic [31:0] rf_fp_wdata_o
);

  localparam int unsigned PtrW = $clog2(FpQDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FpQDepth);

  logic            wb_int, wb_fp;
  logic            push, pop, q_nonempty;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      q_waddr_q [FpQDepth];
  logic [31:0]     q_wdata_q [FpQDepth];
  logic [FpQDepth-1:0] entry_hit;

  assign wb_int = wb_we_int_i & ~wb_lsu_to_fp_i;
  assign wb_fp  = wb_we_fp_i | (wb_we_int_i & wb_lsu_to_fp_i);

  assign q_nonempty   = (count_q != '0);
  assign fpu_ready_o  = (count_q != DepthCnt);
  assign fp_pending_o = q_nonempty;

  assign push = fpu_valid_i & fpu_ready_o;
  assign pop  = ~wb_fp & q_nonempty;

  always_comb begin
    rf_int_we_o    = wb_int;
    rf_int_waddr_o = wb_int ? wb_waddr_i : 5'd0;
    rf_int_wdata_o = wb_int ? wb_wdata_i : 32'd0;
  end

  // The writeback stage cannot stall, so it always wins the FP port.
  always_comb begin
    rf_fp_we_o    = 1'b0;
    rf_fp_waddr_o = 5'd0;
    rf_fp_wdata_o = 32'd0;
    if (wb_fp) begin
      rf_fp_we_o    = 1'b1;
      rf_fp_waddr_o = wb_waddr_i;
      rf_fp_wdata_o = wb_wdata_i;
    end else if (q_nonempty) begin
      rf_fp_we_o    = 1'b1;
      rf_fp_waddr_o = q_waddr_q[rd_ptr_q];
      rf_fp_wdata_o = q_wdata_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  generate
    if (ResetAll) begin : g_storage_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < FpQDepth; i++) begin
            q_waddr_q[i] <= 5'd0;
            q_wdata_q[i] <= 32'd0;
          end
        end else if (push) begin
          q_waddr_q[wr_ptr_q] <= fpu_waddr_i;
          q_wdata_q[wr_ptr_q] <= fpu_wdata_i;
        end
      end
    end else begin : g_storage_norst
      always_ff @(posedge clk_i) begin
        if (push) begin
          q_waddr_q[wr_ptr_q] <= fpu_waddr_i;
          q_wdata_q[wr_ptr_q] <= fpu_wdata_i;
        end
      end
    end
  endgenerate

  // An entry is live when its distance from the read pointer is below the count;
  // this includes the head being popped this cycle but not the entry being pushed.
  generate
    for (genvar gi = 0; gi < FpQDepth; gi++) begin : g_hazard
      logic [PtrW-1:0] offset;
      assign offset        = PtrW'(gi) - rd_ptr_q;
      assign entry_hit[gi] = ({1'b0, offset} < count_q) && (q_waddr_q[gi] == hazard_raddr_i);
    end
  endgenerate

  assign hazard_o = |entry_hit;

  WbSingleTarget: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wb_int && wb_fp));

  FpuInputsStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fpu_valid_i && !fpu_ready_o) |=>
      (fpu_valid_i && $stable(fpu_waddr_i) && $stable(fpu_wdata_i)));

  CountInRange: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= DepthCnt);

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter: a per-cycle vector table plus hand sequences
// for asynchronous reset with queued entries and pointer wrap-around.
module tb_ibex_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        wb_we_int_i, wb_we_fp_i, wb_lsu_to_fp_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_waddr_i;
  logic [31:0] fpu_wdata_i;
  logic [4:0]  hazard_raddr_i;
  logic        hazard_o, fp_pending_o;
  logic        rf_int_we_o;
  logic [4:0]  rf_int_waddr_o;
  logic [31:0] rf_int_wdata_o;
  logic        rf_fp_we_o;
  logic [4:0]  rf_fp_waddr_o;
  logic [31:0] rf_fp_wdata_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_arbiter #(.ResetAll(1'b0), .FpQDepth(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_waddr_i     (wb_waddr_i),
    .wb_wdata_i     (wb_wdata_i),
    .wb_we_int_i    (wb_we_int_i),
    .wb_we_fp_i     (wb_we_fp_i),
    .wb_lsu_to_fp_i (wb_lsu_to_fp_i),
    .fpu_valid_i    (fpu_valid_i),
    .fpu_ready_o    (fpu_ready_o),
    .fpu_waddr_i    (fpu_waddr_i),
    .fpu_wdata_i    (fpu_wdata_i),
    .hazard_raddr_i (hazard_raddr_i),
    .hazard_o       (hazard_o),
    .fp_pending_o   (fp_pending_o),
    .rf_int_we_o    (rf_int_we_o),
    .rf_int_waddr_o (rf_int_waddr_o),
    .rf_int_wdata_o (rf_int_wdata_o),
    .rf_fp_we_o     (rf_fp_we_o),
    .rf_fp_waddr_o  (rf_fp_waddr_o),
    .rf_fp_wdata_o  (rf_fp_wdata_o)
  );

  typedef struct {
    logic        we_int, we_fp, lsu_fp;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic [4:0]  hr;
    logic        e_iwe;
    logic [4:0]  e_ia;
    logic [31:0] e_id;
    logic        e_fwe;
    logic [4:0]  e_fa;
    logic [31:0] e_fd;
    logic        e_rdy, e_haz, e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic we_int, logic we_fp, logic lsu_fp, logic [4:0] waddr, logic [31:0] wdata,
    logic fv, logic [4:0] fa, logic [31:0] fd, logic [4:0] hr,
    logic e_iwe, logic [4:0] e_ia, logic [31:0] e_id,
    logic e_fwe, logic [4:0] e_fa, logic [31:0] e_fd,
    logic e_rdy, logic e_haz, logic e_pend);
    vec_t v;
    v.we_int = we_int; v.we_fp = we_fp; v.lsu_fp = lsu_fp; v.waddr = waddr; v.wdata = wdata;
    v.fv = fv; v.fa = fa; v.fd = fd; v.hr = hr;
    v.e_iwe = e_iwe; v.e_ia = e_ia; v.e_id = e_id;
    v.e_fwe = e_fwe; v.e_fa = e_fa; v.e_fd = e_fd;
    v.e_rdy = e_rdy; v.e_haz = e_haz; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we_int, input logic we_fp, input logic lsu_fp,
                       input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                       input logic [4:0] hr);
    wb_we_int_i = we_int; wb_we_fp_i = we_fp; wb_lsu_to_fp_i = lsu_fp;
    wb_waddr_i = waddr; wb_wdata_i = wdata;
    fpu_valid_i = fv; fpu_waddr_i = fa; fpu_wdata_i = fd;
    hazard_raddr_i = hr;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".int_we"},   {31'd0, rf_int_we_o},    {31'd0, v.e_iwe});
    chk({tag, ".int_addr"}, {27'd0, rf_int_waddr_o}, {27'd0, v.e_ia});
    chk({tag, ".int_data"}, rf_int_wdata_o,          v.e_id);
    chk({tag, ".fp_we"},    {31'd0, rf_fp_we_o},     {31'd0, v.e_fwe});
    chk({tag, ".fp_addr"},  {27'd0, rf_fp_waddr_o},  {27'd0, v.e_fa});
    chk({tag, ".fp_data"},  rf_fp_wdata_o,           v.e_fd);
    chk({tag, ".ready"},    {31'd0, fpu_ready_o},    {31'd0, v.e_rdy});
    chk({tag, ".hazard"},   {31'd0, hazard_o},       {31'd0, v.e_haz});
    chk({tag, ".pending"},  {31'd0, fp_pending_o},   {31'd0, v.e_pend});
  endtask

  vec_t idle_exp;

  initial begin
    //              int fp lsu wa  wdata         fv fa  fd            hr | iwe ia id       fwe fa  fd            rdy haz pend
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5,  32'h1234,     0, 0,  32'h0,        0,   1, 5, 32'h1234,  0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 3,  32'h3F800000, 0, 0,  32'h0,        0,   0, 0, 32'h0,     1, 3,  32'h3F800000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 9,  32'hAAAA,     0, 0,  32'h0,        0,   0, 0, 32'h0,     1, 9,  32'hAAAA,     1, 0, 0));
    // single FPU result: enqueued, then drained the next cycle
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        1, 7,  32'h40000000, 7,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        7,   0, 0, 32'h0,     1, 7,  32'h40000000, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        7,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    // conflict: three wb_fp cycles hold off f1, f2
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        1, 1,  32'h11111111, 1,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       1, 2,  32'h22222222, 1,   0, 0, 32'h0,     1, 9,  32'h99,       1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       0, 0,  32'h0,        2,   0, 0, 32'h0,     1, 9,  32'h99,       0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       0, 0,  32'h0,        9,   0, 0, 32'h0,     1, 9,  32'h99,       0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0,   0, 0, 32'h0,     1, 1,  32'h11111111, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1,   0, 0, 32'h0,     1, 2,  32'h22222222, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        2,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    // f0 is a real register for hazard purposes
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        1, 0,  32'h5,        0,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0,   0, 0, 32'h0,     1, 0,  32'h5,        1, 1, 1));
    // full queue: f3 held off until the cycle after the first pop
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       1, 1,  32'hA1,       1,   0, 0, 32'h0,     1, 9,  32'h99,       1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       1, 2,  32'hA2,       1,   0, 0, 32'h0,     1, 9,  32'h99,       1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 9,  32'h99,       1, 3,  32'hA3,       3,   0, 0, 32'h0,     1, 9,  32'h99,       0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4,  32'h44,       1, 3,  32'hA3,       3,   1, 4, 32'h44,    1, 1,  32'hA1,       0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        1, 3,  32'hA3,       3,   0, 0, 32'h0,     1, 2,  32'hA2,       1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        3,   0, 0, 32'h0,     1, 3,  32'hA3,       1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        3,   0, 0, 32'h0,     0, 0,  32'h0,        1, 0, 0));

    idle_exp = mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0);

    drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", idle_exp);
    $display("reset state checked");
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk_i);
      #1;
      drive(vecs[i].we_int, vecs[i].we_fp, vecs[i].lsu_fp, vecs[i].waddr, vecs[i].wdata,
            vecs[i].fv, vecs[i].fa, vecs[i].fd, vecs[i].hr);
      #3;
      check_all($sformatf("v%0d", i), vecs[i]);
      $display("vec %0d: fp_we=%0b fp_addr=%0d fp_data=0x%0h ready=%0b hazard=%0b pending=%0b",
               i, rf_fp_we_o, rf_fp_waddr_o, rf_fp_wdata_o, fpu_ready_o, hazard_o, fp_pending_o);
    end

    // Reset with two entries queued: clears asynchronously, no stale write afterwards.
    @(posedge clk_i); #1;
    drive(0, 1, 0, 9, 32'h99, 1, 5, 32'h55, 0);
    @(posedge clk_i); #1;
    drive(0, 1, 0, 9, 32'h99, 1, 6, 32'h66, 0);
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 5);
    #1;
    chk("rstseq.pre_pending", {31'd0, fp_pending_o}, 32'd1);
    chk("rstseq.pre_fp_addr", {27'd0, rf_fp_waddr_o}, 32'd5);
    rst_ni = 1'b0;
    #1;
    check_all("rstseq.async", idle_exp);
    $display("async reset with queued entries checked");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      chk($sformatf("rstseq.post%0d.fp_we", c), {31'd0, rf_fp_we_o}, 32'd0);
      chk($sformatf("rstseq.post%0d.pending", c), {31'd0, fp_pending_o}, 32'd0);
      $display("post-reset cycle %0d: fp_we=%0b pending=%0b", c, rf_fp_we_o, fp_pending_o);
    end

    // Ten back-to-back push/pop pairs walk the pointers around the ring.
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk_i); #1;
      if (i < 10) drive(0, 0, 0, 0, 32'h0, 1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 0);
      else        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
      #3;
      if (i == 0) begin
        chk("wrap0.fp_we", {31'd0, rf_fp_we_o}, 32'd0);
      end else begin
        chk($sformatf("wrap%0d.fp_we", i), {31'd0, rf_fp_we_o}, 32'd1);
        chk($sformatf("wrap%0d.fp_addr", i), {27'd0, rf_fp_waddr_o}, 32'(10 + i - 1));
        chk($sformatf("wrap%0d.fp_data", i), rf_fp_wdata_o, 32'hC0DE0000 + 32'(i - 1));
      end
      $display("wrap %0d: fp_we=%0b fp_addr=%0d fp_data=0x%0h", i, rf_fp_we_o, rf_fp_waddr_o, rf_fp_wdata_o);
    end
    @(posedge clk_i); #1;
    chk("wrap.end_pending", {31'd0, fp_pending_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
